// File: rtl/qdrc_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : qdrc_rd_arb
// Brief    : Round-robin arbiter sharing the QDR controller read channel among
//            NUM_PORTS requesters. An in-order tag FIFO steers returned read
//            words back to their requester. Optional macro QDRC_RD_ARB_ERR_EN
//            adds a sticky rd_err output.
// Revision : 1.0 - initial release
// ============================================================================
module qdrc_rd_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 21,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            phy_rdy,
    input  logic [NUM_PORTS-1:0]            req_strb,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]            req_ack,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_PORTS-1:0]            rsp_dvld,
    output logic                            qdr_rd_strb,
    output logic [ADDR_WIDTH-1:0]           qdr_rd_addr,
    input  logic [2*DATA_WIDTH-1:0]         qdr_rd_data,
    input  logic                            qdr_rd_dvld,
    output logic [$clog2(TAG_DEPTH):0]      outstanding
`ifdef QDRC_RD_ARB_ERR_EN
    ,
    output logic                            rd_err
`endif
);

    localparam int c_tag_w = $clog2(NUM_PORTS);
    localparam int c_ptr_w = $clog2(TAG_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_tag_w-1:0]      r_rr;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic [c_tag_w-1:0]      r_tag_mem [TAG_DEPTH];
    logic                    r_rd_strb;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [NUM_PORTS-1:0]    r_rsp_dvld;
    logic [2*DATA_WIDTH-1:0] r_rsp_data;

    logic [ADDR_WIDTH-1:0]   w_addr [NUM_PORTS];
    logic [c_tag_w:0]        w_sum;
    logic [c_tag_w-1:0]      w_idx;
    logic [c_tag_w-1:0]      w_win;
    logic                    w_found;
    logic                    w_grant;
    logic                    w_pop;
    logic [c_tag_w-1:0]      w_head_tag;
    logic [NUM_PORTS-1:0]    w_head_onehot;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_addr
        assign w_addr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Search from the rr pointer upward, wrapping modulo NUM_PORTS.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, r_rr} + (c_tag_w+1)'(k);
            if (w_sum >= (c_tag_w+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (c_tag_w+1)'(NUM_PORTS);
            end
            w_idx = w_sum[c_tag_w-1:0];
            if (!w_found && req_strb[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Registered occupancy only: a same-cycle pop does not open a slot.
    assign w_grant = reset_n & phy_rdy & w_found & (r_count < c_cnt_w'(TAG_DEPTH));
    assign w_pop   = qdr_rd_dvld & (r_count != '0);

    always_comb begin
        req_ack = '0;
        if (w_grant) begin
            req_ack[w_win] = 1'b1;
        end
    end

    assign w_head_tag = r_tag_mem[r_rd_ptr];

    always_comb begin
        w_head_onehot = '0;
        w_head_onehot[w_head_tag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag_mem[r_wr_ptr] <= w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_strb  <= 1'b0;
            r_rd_addr  <= '0;
            r_rsp_dvld <= '0;
            r_rsp_data <= '0;
        end else begin
            r_rd_strb <= w_grant;
            if (w_grant) begin
                r_rd_addr <= w_addr[w_win];
                r_rr      <= (w_win == c_tag_w'(NUM_PORTS-1)) ? '0 : w_win + 1'b1;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end
            r_rsp_dvld <= w_pop ? w_head_onehot : '0;
            if (w_pop) begin
                r_rsp_data <= qdr_rd_data;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign qdr_rd_strb = r_rd_strb;
    assign qdr_rd_addr = r_rd_addr;
    assign rsp_dvld    = r_rsp_dvld;
    assign rsp_data    = r_rsp_data;
    assign outstanding = r_count;

`ifdef QDRC_RD_ARB_ERR_EN
    logic r_err;

    // An empty registered FIFO also covers a return racing a push into it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (qdr_rd_dvld && (r_count == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign rd_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qdrc_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_qdrc_rd_arb
// Brief    : Self-checking bench for qdrc_rd_arb with a latency-9 controller
//            model and a queue-based reference of grants and returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qdrc_rd_arb;

    localparam int NP = 4;
    localparam int DW = 36;
    localparam int AW = 21;
    localparam int TD = 16;
    localparam int CW = 5;

    logic              clk;
    logic              reset_n;
    logic              phy_rdy;
    logic [NP-1:0]     req_strb;
    logic [NP*AW-1:0]  req_addr;
    logic [NP-1:0]     req_ack;
    logic [2*DW-1:0]   rsp_data;
    logic [NP-1:0]     rsp_dvld;
    logic              qdr_rd_strb;
    logic [AW-1:0]     qdr_rd_addr;
    logic [2*DW-1:0]   qdr_rd_data;
    logic              qdr_rd_dvld;
    logic [CW-1:0]     outstanding;
`ifdef QDRC_RD_ARB_ERR_EN
    logic              rd_err;
`endif

    qdrc_rd_arb #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phy_rdy    (phy_rdy),
        .req_strb   (req_strb),
        .req_addr   (req_addr),
        .req_ack    (req_ack),
        .rsp_data   (rsp_data),
        .rsp_dvld   (rsp_dvld),
        .qdr_rd_strb(qdr_rd_strb),
        .qdr_rd_addr(qdr_rd_addr),
        .qdr_rd_data(qdr_rd_data),
        .qdr_rd_dvld(qdr_rd_dvld),
        .outstanding(outstanding)
`ifdef QDRC_RD_ARB_ERR_EN
        ,
        .rd_err     (rd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [2*DW-1:0] data;
    } ret_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // scenario drive
    logic            drv_rst_n = 1'b0;
    logic            drv_phy   = 1'b1;
    logic [NP-1:0]   drv_strb  = '0;
    logic [NP*AW-1:0] drv_addr = '0;
    logic            ctl_auto  = 1'b1;
    logic            force_dv  = 1'b0;
    logic            use_fixed = 1'b0;
    logic [2*DW-1:0] fixed_data = '0;

    // reference model
    int              m_rr = 0;
    int              m_tags[$];
    ret_t            ret_q[$];
    logic            m_err = 1'b0;
    int              win;
    logic            dv;
    logic [2*DW-1:0] dd;
    logic [NP-1:0]   exp_ack, exp_rsp_dvld, n_rsp_dvld;
    logic            exp_strb, n_strb, exp_err;
    logic [AW-1:0]   exp_addr, n_addr;
    logic [2*DW-1:0] exp_rsp_data, n_rsp_data;
    logic [CW-1:0]   exp_out;

    initial begin
        n_strb = 1'b0; n_addr = '0; n_rsp_dvld = '0; n_rsp_data = '0;
        reset_n = 1'b0; phy_rdy = 1'b0; req_strb = '0; req_addr = '0;
        qdr_rd_data = '0; qdr_rd_dvld = 1'b0;
    end

    function automatic logic [2*DW-1:0] rand72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[2*DW-1:0];
    endfunction

    // One clock cycle: drive after posedge, sample at negedge, advance model.
    task automatic cycle();
        ret_t r;
        @(posedge clk);
        cyc++;
        exp_strb     = n_strb;
        exp_addr     = n_addr;
        exp_rsp_dvld = n_rsp_dvld;
        exp_rsp_data = n_rsp_data;
        exp_out      = CW'(m_tags.size());
        exp_err      = m_err;
        #1;
        reset_n  = drv_rst_n;
        phy_rdy  = drv_phy;
        req_strb = drv_strb;
        req_addr = drv_addr;
        dv = 1'b0;
        dd = qdr_rd_data;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            dv = 1'b1;
            dd = ret_q[0].data;
            ret_q.delete(0);
        end
        if (force_dv) begin
            dv = 1'b1;
            dd = rand72();
            force_dv = 1'b0;
        end
        qdr_rd_dvld = dv;
        qdr_rd_data = dd;
        exp_ack = '0;
        win = -1;
        if (drv_rst_n && drv_phy && m_tags.size() < TD) begin
            for (int k = 0; k < NP; k++) begin
                if (win < 0 && drv_strb[(m_rr + k) % NP]) win = (m_rr + k) % NP;
            end
        end
        if (win >= 0) exp_ack[win] = 1'b1;
        @(negedge clk);
        if (ctl_auto && qdr_rd_strb === 1'b1) begin
            r.due  = cyc + 9;
            r.data = use_fixed ? fixed_data : rand72();
            ret_q.push_back(r);
        end
        if (!drv_rst_n) begin
            m_rr = 0;
            m_tags.delete();
            m_err = 1'b0;
            n_strb = 1'b0; n_addr = '0; n_rsp_dvld = '0; n_rsp_data = '0;
        end else begin
            if (dv && m_tags.size() == 0) m_err = 1'b1;
            n_strb = (win >= 0);
            n_rsp_dvld = '0;
            if (dv && m_tags.size() > 0) begin
                n_rsp_dvld[m_tags[0]] = 1'b1;
                n_rsp_data = dd;
                m_tags.delete(0);
            end
            if (win >= 0) begin
                n_addr = drv_addr[win*AW +: AW];
                m_tags.push_back(win);
                m_rr = (win + 1) % NP;
            end
        end
    endtask

    task automatic do_reset();
        drv_rst_n = 1'b0;
        drv_strb  = '0;
        cycle();
        drv_rst_n = 1'b1;
        repeat (12) cycle();
    endtask

    task automatic test_reset();
        drv_rst_n = 1'b0;
        drv_phy   = 1'b1;
        drv_strb  = '1;
        cycle();
        cycle();
        checks++;
        if (req_ack !== '0) begin errors++; $display("FAIL reset_ack got %b want 0000", req_ack); end
        checks++;
        if (outstanding !== '0) begin errors++; $display("FAIL reset_out got %0d want 0", outstanding); end
        checks++;
        if ({qdr_rd_strb, qdr_rd_addr, rsp_dvld} !== '0) begin
            errors++; $display("FAIL reset_issue strb=%b addr=%h dvld=%b want zeros", qdr_rd_strb, qdr_rd_addr, rsp_dvld);
        end
        checks++;
        if (rsp_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", rsp_data); end
`ifdef QDRC_RD_ARB_ERR_EN
        checks++;
        if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rd_err); end
`endif
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        use_fixed  = 1'b1;
        fixed_data = 72'h123456789AB;
        drv_addr[2*AW +: AW] = 21'h00ABC;
        drv_strb = 4'b0100;
        cycle();
        checks++;
        if (req_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", req_ack); end
        drv_strb = '0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            checks++;
            if ({req_ack, qdr_rd_strb, rsp_dvld, outstanding} !== {exp_ack, exp_strb, exp_rsp_dvld, exp_out}) begin
                errors++;
                $display("FAIL single_state cyc=%0d ack,strb,dvld,out got %h,%b,%h,%0d want %h,%b,%h,%0d",
                         cyc, req_ack, qdr_rd_strb, rsp_dvld, outstanding, exp_ack, exp_strb, exp_rsp_dvld, exp_out);
            end
            if (i == 1) begin
                checks++;
                if (qdr_rd_strb !== 1'b1 || qdr_rd_addr !== 21'h00ABC) begin
                    errors++; $display("FAIL single_issue strb=%b addr=%h want 1 00abc", qdr_rd_strb, qdr_rd_addr);
                end
            end
            if (i == 11) begin
                checks++;
                if (rsp_dvld !== 4'b0100 || rsp_data !== 72'h123456789AB) begin
                    errors++; $display("FAIL single_rsp dvld=%b data=%h want 0100 123456789ab", rsp_dvld, rsp_data);
                end
            end
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_rotate();
        logic [NP-1:0] lit;
        do_reset();
        for (int p = 0; p < NP; p++) drv_addr[p*AW +: AW] = AW'($urandom());
        drv_strb = '1;
        for (int i = 0; i < 34; i++) begin
            if (i == 20) drv_strb = '0;
            cycle();
            checks++;
            if ({req_ack, qdr_rd_strb, rsp_dvld, outstanding} !== {exp_ack, exp_strb, exp_rsp_dvld, exp_out}) begin
                errors++;
                $display("FAIL rotate_state cyc=%0d ack,strb,dvld,out got %h,%b,%h,%0d want %h,%b,%h,%0d",
                         cyc, req_ack, qdr_rd_strb, rsp_dvld, outstanding, exp_ack, exp_strb, exp_rsp_dvld, exp_out);
            end
            if (exp_strb) begin
                checks++;
                if (qdr_rd_addr !== exp_addr) begin errors++; $display("FAIL rotate_addr cyc=%0d got %h want %h", cyc, qdr_rd_addr, exp_addr); end
            end
            if (exp_rsp_dvld != '0) begin
                checks++;
                if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL rotate_data cyc=%0d got %h want %h", cyc, rsp_data, exp_rsp_data); end
            end
            if (i < 20) begin
                lit = NP'(1) << (i % NP);
                checks++;
                if (req_ack !== lit) begin errors++; $display("FAIL rotate_order i=%0d got %b want %b", i, req_ack, lit); end
                for (int p = 0; p < NP; p++) if (exp_ack[p]) drv_addr[p*AW +: AW] = AW'($urandom());
            end
        end
    endtask

    task automatic test_full();
        int acks = 0;
        do_reset();
        ctl_auto = 1'b0;
        drv_strb = 4'b0001;
        for (int i = 0; i < 23; i++) begin
            if (i == 20) force_dv = 1'b1;
            cycle();
            if (req_ack != '0) acks++;
            checks++;
            if ({req_ack, rsp_dvld, outstanding} !== {exp_ack, exp_rsp_dvld, exp_out}) begin
                errors++;
                $display("FAIL full_state cyc=%0d ack,dvld,out got %h,%h,%0d want %h,%h,%0d",
                         cyc, req_ack, rsp_dvld, outstanding, exp_ack, exp_rsp_dvld, exp_out);
            end
            if (i == 19) begin
                checks++;
                if (acks != 16 || outstanding !== 5'd16) begin
                    errors++; $display("FAIL full_limit acks=%0d out=%0d want 16 16", acks, outstanding);
                end
            end
            if (i == 21) begin
                checks++;
                if (outstanding !== 5'd15 || req_ack !== 4'b0001) begin
                    errors++; $display("FAIL full_free out=%0d ack=%b want 15 0001", outstanding, req_ack);
                end
            end
        end
        drv_strb = '0;
        ctl_auto = 1'b1;
    endtask

    task automatic test_phy();
        do_reset();
        drv_strb = 4'b0010;
        cycle();
        drv_phy  = 1'b0;
        drv_strb = '1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (req_ack !== '0 || (i > 0 && qdr_rd_strb !== 1'b0)) begin
                errors++; $display("FAIL phy_block i=%0d ack=%b strb=%b want 0000 0", i, req_ack, qdr_rd_strb);
            end
            checks++;
            if ({rsp_dvld, outstanding} !== {exp_rsp_dvld, exp_out}) begin
                errors++; $display("FAIL phy_drain cyc=%0d dvld,out got %h,%0d want %h,%0d", cyc, rsp_dvld, outstanding, exp_rsp_dvld, exp_out);
            end
        end
        drv_phy = 1'b1;
        cycle();
        checks++;
        if (req_ack !== 4'b0100) begin errors++; $display("FAIL phy_resume got %b want 0100", req_ack); end
        drv_strb = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if ({req_ack, qdr_rd_strb, rsp_dvld, outstanding} !== {exp_ack, exp_strb, exp_rsp_dvld, exp_out}) begin
                errors++;
                $display("FAIL phy_state cyc=%0d ack,strb,dvld,out got %h,%b,%h,%0d want %h,%b,%h,%0d",
                         cyc, req_ack, qdr_rd_strb, rsp_dvld, outstanding, exp_ack, exp_strb, exp_rsp_dvld, exp_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drv_strb = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (req_ack !== exp_ack) begin errors++; $display("FAIL rmid_ack cyc=%0d got %b want %b", cyc, req_ack, exp_ack); end
            drv_strb = drv_strb & ~exp_ack;
        end
        drv_rst_n = 1'b0;
        cycle();
        drv_rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++;
            if (rsp_dvld !== '0 || outstanding !== '0) begin
                errors++; $display("FAIL rmid_drop cyc=%0d dvld=%b out=%0d want 0000 0", cyc, rsp_dvld, outstanding);
            end
`ifdef QDRC_RD_ARB_ERR_EN
            checks++;
            if (rd_err !== exp_err) begin errors++; $display("FAIL rmid_err cyc=%0d got %b want %b", cyc, rd_err, exp_err); end
`endif
        end
`ifdef QDRC_RD_ARB_ERR_EN
        checks++;
        if (rd_err !== 1'b1) begin errors++; $display("FAIL rmid_err_sticky got %b want 1", rd_err); end
`endif
    endtask

    task automatic test_push_pop();
        do_reset();
        ctl_auto = 1'b0;
        for (int p = 0; p < NP; p++) drv_addr[p*AW +: AW] = AW'($urandom());
        drv_strb = '1;
        for (int i = 0; i < 22; i++) begin
            if (i == 5) drv_strb = '0;
            if (i == 7) begin drv_strb = 4'b0100; force_dv = 1'b1; end
            if (i == 8) drv_strb = '0;
            if (i > 9 && (i % 2) == 0) force_dv = 1'b1;
            cycle();
            checks++;
            if ({req_ack, qdr_rd_strb, rsp_dvld, outstanding} !== {exp_ack, exp_strb, exp_rsp_dvld, exp_out}) begin
                errors++;
                $display("FAIL pp_state cyc=%0d ack,strb,dvld,out got %h,%b,%h,%0d want %h,%b,%h,%0d",
                         cyc, req_ack, qdr_rd_strb, rsp_dvld, outstanding, exp_ack, exp_strb, exp_rsp_dvld, exp_out);
            end
            if (exp_rsp_dvld != '0) begin
                checks++;
                if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL pp_data cyc=%0d got %h want %h", cyc, rsp_data, exp_rsp_data); end
            end
            if (i == 6) begin
                checks++;
                if (outstanding !== 5'd5) begin errors++; $display("FAIL pp_pre out=%0d want 5", outstanding); end
            end
            if (i == 8) begin
                checks++;
                if (outstanding !== 5'd5 || rsp_dvld !== 4'b0001) begin
                    errors++; $display("FAIL pp_same out=%0d dvld=%b want 5 0001", outstanding, rsp_dvld);
                end
            end
        end
        ctl_auto = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                for (int p = 0; p < NP; p++) begin
                    if (!drv_strb[p] && $urandom_range(0, 2) == 0) begin
                        drv_strb[p] = 1'b1;
                        drv_addr[p*AW +: AW] = AW'($urandom());
                    end
                end
                drv_phy = ($urandom_range(0, 9) != 0);
            end else begin
                drv_strb = '0;
                drv_phy  = 1'b1;
            end
            cycle();
            checks++;
            if ({req_ack, qdr_rd_strb, rsp_dvld, outstanding} !== {exp_ack, exp_strb, exp_rsp_dvld, exp_out}) begin
                errors++;
                $display("FAIL rand_state cyc=%0d ack,strb,dvld,out got %h,%b,%h,%0d want %h,%b,%h,%0d",
                         cyc, req_ack, qdr_rd_strb, rsp_dvld, outstanding, exp_ack, exp_strb, exp_rsp_dvld, exp_out);
            end
            if (exp_strb) begin
                checks++;
                if (qdr_rd_addr !== exp_addr) begin errors++; $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, qdr_rd_addr, exp_addr); end
            end
            if (exp_rsp_dvld != '0) begin
                checks++;
                if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL rand_data cyc=%0d got %h want %h", cyc, rsp_data, exp_rsp_data); end
            end
            drv_strb = drv_strb & ~exp_ack;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_full();
        test_phy();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
